instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, packs each four bytes big-endian into a 32-bit MIPS instruction word, and issues single-cycle write strobes to the instruction memory's write port at consecutive word addresses. It sits between the host/debug byte link and the instruction memory and holds the processor off (`busy`) until the program image is written.

## Interface

Parameters:
- `DEPTH`, 256: instruction memory capacity in 32-bit words; maximum legal `length`.
- `LEN_W`, 9: width of `length`; must hold `DEPTH` (clog2(DEPTH)+1).

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: load request; sampled only in IDLE.
- `length` in LEN_W: number of words to load; sampled with `start`.
- `base_addr` in 32: byte address of the first word; sampled with `start`; bits [1:0] forced to 0.
- `byte_valid` in 1: `byte_data` holds a valid byte.
- `byte_data` in 8: stream byte, most significant byte of each word first.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: instruction memory write strobe, one cycle per word.
- `mem_addr` out 32: byte address of the write.
- `mem_wdata` out 32: instruction word written.
- `busy` out 1: load in progress; the processor is held while high.
- `done` out 1: one-cycle pulse at the end of every accepted `start`.
- `error` out 1: sticky; set on a rejected `length`, cleared by the next accepted `start`.

## Operation

- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: `byte_ready`=0, `busy`=0. On `start`:
  - latch `length`, `base_addr`, clear `error`, word index = 0, byte count = 0;
  - `length`==0 -> DONE, no writes;
  - `length`>DEPTH -> set `error`, DONE, no writes;
  - otherwise -> COLLECT.
- COLLECT: `byte_ready`=1, `busy`=1. Each cycle with `byte_valid`&&`byte_ready`:
  - shift in: word <= {word[23:0], byte_data};
  - byte count++;
  - on the 4th byte -> WRITE.
  - `byte_valid` low simply stalls; no timeout.
- WRITE: `byte_ready`=0, `busy`=1. `mem_we`=1 for exactly this cycle.
  - `mem_addr` = base + 4·index, modulo 2^32, so wrap-around is silent.
  - `mem_wdata` = assembled word.
  - index++, byte count = 0.
  - If index+1 == `length` -> DONE; else -> COLLECT.
- DONE: `done`=1 for one cycle, `busy`=0 -> IDLE.
- `start` outside IDLE is ignored; no queuing.
- Outputs are registered; `mem_addr` and `mem_wdata` hold their last values outside WRITE.
- Reset mid-load:
  - immediately returns to IDLE with all outputs at reset values;
  - the partial word is discarded; words already written remain in memory.

## Timing

- Reset values:
  - `byte_ready`, `mem_we`, `busy`, `done`, `error` = 0;
  - `mem_addr`, `mem_wdata` = 0x00000000.
- `start` at edge T -> `busy`/`byte_ready` high from T+1.
- The 4th byte accepted at edge N -> `mem_we` high during cycle N+1 -> `byte_ready` high again at N+2.
- Last write at cycle W -> `done` high at W+1, `busy` low from W+1.
- Minimum 5 cycles per word; a full load of L words takes at least 5L+2 cycles from `start` to `done`.
- Rejected or zero `length`: `done` pulses in the cycle after `start`; `error` is valid in the same cycle as `done`.

## Structure

- Shared package (instr_mem_pkg):
  - `DEPTH` default, word width 32, byte width 8;
  - state encoding localparams (IDLE/COLLECT/WRITE/DONE);
  - shared with the instruction memory and the fetch logic.
- Sub-module `byte_packer`: 4-byte big-endian shift assembler with a 2-bit byte counter and a `word_ready` flag. It is cleared by the FSM and provides the assembled word to the FSM.

## Test plan

- Reset then `start`, `length`=2, `base_addr`=0x00400000, bytes 20 08 00 05 8C 09 00 04 with valid held high:
  - writes 0x20080005 @0x00400000, then 0x8C090004 @0x00400004;
  - `done` one cycle after the second `mem_we`.
- `length`=1, `byte_valid` toggled every other cycle: exactly one `mem_we`, with the correct word; `byte_ready` never high in WRITE.
- `length`=0 -> `done` at T+1, no `mem_we`, `error`=0. `length`=DEPTH+1 -> `done` at T+1, `error`=1, no writes; the next valid `start` clears `error`.
- `rst_n` pulsed low after 2 bytes of word 1 (one word already written):
  - all outputs are 0 at once;
  - a fresh load rewrites from the base;
  - no stale bytes appear in the first word.
- `base_addr`=0xFFFFFFFE, `length`=2:
  - addresses 0xFFFFFFFC then 0x00000000 (alignment forced, wrap);
  - `start` pulsed during COLLECT is ignored.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory, its boot loader and fetch logic.
package instr_mem_pkg;

  localparam int DEPTH_DEF = 256;
  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_WRITE   = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface instr_mem_loader_if;
  import instr_mem_pkg::*;

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  // loader side
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  // host / memory side
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Big-endian 4-byte shift assembler; word_ready marks the cycle the 4th byte is taken.
module byte_packer
  import instr_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  logic [WORD_W-1:0] word_q;
  logic [1:0]        cnt;

  // Shift register and byte counter; clear wipes partial words so nothing stale survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt    <= '0;
    end else if (clr) begin
      word_q <= '0;
      cnt    <= '0;
    end else if (shift_en) begin
      word_q <= {word_q[23:0], byte_data};
      cnt    <= cnt + 2'd1;
    end
  end

  // The word including the byte being accepted, so the FSM can register it on the same edge.
  always_comb begin
    word       = {word_q[23:0], byte_data};
    word_ready = shift_en && (cnt == 2'd3);
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time loader: packs a byte stream into words and writes them to instruction memory.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN_W = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    length,
  input  logic [WORD_W-1:0]   base_addr,
  instr_mem_loader_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                error
);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [WORD_W-1:0] base_q;
  logic              byte_ready_q;
  logic              mem_we_q;
  logic [WORD_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;
  logic              pk_clr;
  logic              pk_shift;
  logic [WORD_W-1:0] pk_word;
  logic              pk_ready;
  logic              len_bad;
  logic [WORD_W-1:0] offset;

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  assign pk_shift = bus.byte_valid && byte_ready_q;
  assign pk_clr   = (state == ST_IDLE) || (state == ST_WRITE);
  assign len_bad  = length > LEN_W'(DEPTH);
  assign offset   = {{(WORD_W-LEN_W-2){1'b0}}, idx, 2'b00};

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .shift_en   (pk_shift),
    .byte_data  (bus.byte_data),
    .word       (pk_word),
    .word_ready (pk_ready)
  );

  // Next-state decode; outputs are registered from state_nxt so they line up with the state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = (length == '0 || len_bad) ? ST_DONE : ST_COLLECT;
      ST_COLLECT: if (pk_ready) state_nxt = ST_WRITE;
      ST_WRITE:   state_nxt = ((idx + LEN_W'(1)) == len_q) ? ST_DONE : ST_COLLECT;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State, load context and registered outputs; mem_addr/mem_wdata only move on a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      idx          <= '0;
      base_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      byte_ready_q <= (state_nxt == ST_COLLECT);
      mem_we_q     <= (state_nxt == ST_WRITE);
      busy         <= (state_nxt == ST_COLLECT) || (state_nxt == ST_WRITE);
      done         <= (state_nxt == ST_DONE);
      if (state == ST_IDLE && start) begin
        len_q  <= length;
        base_q <= base_addr & 32'hFFFF_FFFC;
        idx    <= '0;
        error  <= len_bad;
      end
      if (state == ST_WRITE) idx <= idx + LEN_W'(1);
      if (state_nxt == ST_WRITE) begin
        mem_addr_q  <= base_q + offset;
        mem_wdata_q <= pk_word;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus queues expected writes/done pulses, a monitor checks them.
module tb_instr_mem_loader;
  import instr_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int LEN_W = 9;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic err;
    logic after_we;
  } dn_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] length;
  logic [31:0]      base_addr;
  logic             busy, done, error;

  instr_mem_loader_if bus ();

  instr_mem_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .length    (length),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;
  wr_t exp_wr[$];
  dn_t exp_dn[$];
  logic prev_we = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every write strobe and done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        n_writes++;
        check("ready_during_write", {31'd0, bus.byte_ready}, 32'd0);
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("mem_addr", bus.mem_addr, w.addr);
          check("mem_wdata", bus.mem_wdata, w.data);
        end
      end
      if (done) begin
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (exp_dn.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          dn_t d;
          d = exp_dn.pop_front();
          check("error_at_done", {31'd0, error}, {31'd0, d.err});
          check("done_vs_write", {31'd0, prev_we}, {31'd0, d.after_we});
        end
      end
      prev_we <= bus.mem_we;
    end else begin
      prev_we <= 1'b0;
    end
  end

  task automatic do_start(input logic [LEN_W-1:0] len, input logic [31:0] base);
    @(posedge clk); #1;
    start = 1'b1; length = len; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int k = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && k < 50) begin
      @(negedge clk); k++;
    end
    if (k >= 50) check("byte_ready_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    if (gap) begin
      bus.byte_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 60) begin
      @(negedge clk); k++;
    end
    if (k >= 60) check("done_timeout", 32'd1, 32'd0);
    bus.byte_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    check({tag, "_mem_we"},     {31'd0, bus.mem_we},     32'd0);
    check({tag, "_busy"},       {31'd0, busy},           32'd0);
    check({tag, "_done"},       {31'd0, done},           32'd0);
    check({tag, "_error"},      {31'd0, error},          32'd0);
    check({tag, "_mem_addr"},   bus.mem_addr,            32'h0000_0000);
    check({tag, "_mem_wdata"},  bus.mem_wdata,           32'h0000_0000);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; length = '0; base_addr = '0;
    bus.byte_valid = 1'b0; bus.byte_data = '0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // two words, valid held high
    exp_wr.push_back('{32'h0040_0000, 32'h2008_0005});
    exp_wr.push_back('{32'h0040_0004, 32'h8C09_0004});
    exp_dn.push_back('{1'b0, 1'b1});
    do_start(9'd2, 32'h0040_0000);
    @(negedge clk);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("ready_after_start", {31'd0, bus.byte_ready}, 32'd1);
    send_word(32'h2008_0005, 1'b0);
    send_word(32'h8C09_0004, 1'b0);
    wait_done();

    // one word, valid toggled
    exp_wr.push_back('{32'h0000_2000, 32'hDEAD_BEEF});
    exp_dn.push_back('{1'b0, 1'b1});
    do_start(9'd1, 32'h0000_2000);
    send_word(32'hDEAD_BEEF, 1'b1);
    wait_done();

    // zero length
    exp_dn.push_back('{1'b0, 1'b0});
    do_start(9'd0, 32'h0000_3000);
    @(negedge clk);
    check("zero_len_done_t1", {31'd0, done}, 32'd1);
    check("zero_len_error", {31'd0, error}, 32'd0);

    // length over capacity
    exp_dn.push_back('{1'b1, 1'b0});
    do_start(9'(DEPTH + 1), 32'h0000_3000);
    @(negedge clk);
    check("bad_len_done_t1", {31'd0, done}, 32'd1);
    check("bad_len_error", {31'd0, error}, 32'd1);
    @(negedge clk);
    check("error_sticky", {31'd0, error}, 32'd1);

    // reset mid-load after one word plus two bytes; also clears the sticky error
    exp_wr.push_back('{32'h0000_1000, 32'h1122_3344});
    do_start(9'd2, 32'h0000_1000);
    @(negedge clk);
    check("error_cleared_by_start", {31'd0, error}, 32'd0);
    send_word(32'h1122_3344, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    @(negedge clk); rst_n = 1'b1;
    exp_wr.push_back('{32'h0000_1000, 32'h0102_0304});
    exp_dn.push_back('{1'b0, 1'b1});
    do_start(9'd1, 32'h0000_1000);
    send_word(32'h0102_0304, 1'b0);
    wait_done();

    // unaligned base that wraps, with a start pulse ignored during COLLECT
    exp_wr.push_back('{32'hFFFF_FFFC, 32'h0123_4567});
    exp_wr.push_back('{32'h0000_0000, 32'h89AB_CDEF});
    exp_dn.push_back('{1'b0, 1'b1});
    do_start(9'd2, 32'hFFFF_FFFE);
    start = 1'b1; length = 9'd1; base_addr = 32'h0000_0000;
    @(posedge clk); #1;
    start = 1'b0;
    send_word(32'h0123_4567, 1'b0);
    send_word(32'h89AB_CDEF, 1'b0);
    wait_done();

    repeat (10) @(negedge clk);
    check("pending_writes", exp_wr.size(), 32'd0);
    check("pending_dones", exp_dn.size(), 32'd0);
    check("total_writes", n_writes, 32'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
